systolic_array_result_collector: RTL
====================================

Name: systolic_array_result_collector

Overview:
Downstream drain stage for a PE chain. It sits after the last PE's y_out in a column chain of the systolic array, which produces -(x<<s1 + x<<s2) accumulations. It tracks which tail cycles carry valid results using a valid-token delay line matched to chain latency, and captures those results into a small queue. Results leave through a val/rdy stream. Issue is credit-limited so the queue can never overflow.

Parameters:
data_width, 32, width of y words
p_latency, 4, cycles from issue fire at chain head to valid y on y_tail (>=1)
p_fifo_depth, 4, result queue entries (power of 2, >=2)
p_count_nbits, 16, width of result_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (asserted when 0)
in_val  in  1  upstream wants to inject one operand set at chain head this cycle
in_rdy  out  1  collector has credit; a fire is in_val && in_rdy
y_tail  in  data_width  y_out of the last PE in the chain
clear  in  1  synchronous flush
out_val  out  1  result available
out_rdy  in  1  consumer accepts
out_msg  out  data_width  result word (two's complement, passed unmodified)
result_count  out  p_count_nbits  number of results popped since reset/clear

Behaviour:
- Reset (reset==0, async): delay line, queue pointers, occupancy and result_count go to 0; out_val=0; in_rdy=1 after release; out_msg=0.
- Delay line: vsr[0] <= fire; vsr[i] <= vsr[i-1]; capture = vsr[p_latency-1].
- On capture, y_tail is written into the queue at that cycle's edge; the data appears on out_msg the next cycle. There is no bypass, so minimum fire-to-out_val latency is p_latency+1 cycles.
- Credit counter outstanding (0..p_fifo_depth): +1 on fire, -1 on pop (out_val && out_rdy), unchanged when both occur. It counts in-flight tokens plus queue occupancy.
- in_rdy = (outstanding < p_fifo_depth); it is registered-derived only, with no combinational path from in_val, out_rdy or clear.
- Queue: FIFO order; out_val = !empty; out_msg = head entry (holds its last value when empty, not checked).
- A push and a pop in the same cycle are both legal, including at full occupancy. A push when full cannot happen because of the credit counter; the bench asserts this.
- result_count increments on each pop and wraps modulo 2^p_count_nbits.
- clear=1 (sync, highest priority): zero vsr, queue pointers, outstanding and result_count; ignore fire, capture and pop in that cycle. Next cycle: out_val=0, in_rdy=1.
- Reset or clear mid-operation drops all in-flight tokens. Tail values arriving afterwards at old capture slots are not captured.
- y_tail is sampled only on capture cycles; its value is don't-care on other cycles.

Decomposition:
- Shared package systolic_array_pkg: default data_width, the PE chain latency constant (2 cycles per PE on x, 1 on y), and the p_latency derivation helper for an N-PE chain.
- One sub-module: systolic_array_result_queue. It is a p_fifo_depth x data_width FIFO with push/pop/clear, full/empty flags, an async active-low reset and no bypass.
- The delay line, credit counter and result counter stay in the top module.

Test Plan:
- Reset: hold reset=0 mid-traffic with 2 tokens in flight -> out_val=0, in_rdy=1, result_count=0 immediately. After release, no spurious captures occur.
- Single issue: fire at cycle 0, y_tail=0x00000010 at cycle 4 -> out_val=1, out_msg=0x10 at cycle 5. Pop with out_rdy=1 -> result_count=1, out_val=0 at cycle 6.
- Backpressure: out_rdy=0, in_val=1 for 8 cycles -> exactly 4 fires, then in_rdy=0. Drive y_tail=1,2,3,0xFFFFFFF0 on the capture cycles. Set out_rdy=1 -> pops in order 1,2,3,0xFFFFFFF0, then in_rdy=1.
- Concurrent credit: with outstanding=3, fire and pop in the same cycle -> outstanding stays 3 and in_rdy stays 1. Streaming with out_rdy=1 sustains 1 result/cycle.
- Clear: 2 tokens in flight and 1 queued, pulse clear -> next cycle out_val=0, in_rdy=1, result_count=0. No capture occurs at the dropped tokens' slots.
- Counter wrap: p_count_nbits=4, 17 pops -> result_count=1.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared constants and helpers for the systolic array column chain and its drain stage.
package systolic_array_pkg;

    // Default width of the y words travelling down a column chain.
    localparam int c_data_width = 32'd32;

    // Per-PE pipeline depth: x is skewed by two registers per hop, y by one.
    localparam int c_pe_x_latency = 32'd2;
    localparam int c_pe_y_latency = 32'd1;

    // Chain length the collector is sized for by default.
    localparam int c_default_pe_count = 32'd2;

    // Cycles from an issue at the chain head to a valid y on the last PE's
    // output. The x skew accrues on every hop after the first PE, and every
    // PE adds its own y register. Never less than one cycle.
    function automatic int calc_chain_latency(input int pe_count);
        int lat;
        if (pe_count < 32'sd1) begin
            lat = 32'sd1;
        end else begin
            lat = ((pe_count - 32'sd1) * c_pe_x_latency) + (pe_count * c_pe_y_latency);
        end
        return lat;
    endfunction

endpackage

// File: rtl/systolic_array_result_queue.sv
// Small result FIFO: push/pop/clear, full/empty flags, no bypass path.
module systolic_array_result_queue
    import systolic_array_pkg::*;
#(
    parameter int data_width   = c_data_width,
    parameter int p_fifo_depth = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [data_width-1:0] head_o
);

    localparam int aw = $clog2(p_fifo_depth);
    localparam int pw = aw + 32'd1;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [pw-1:0]         wr_ptr_q, wr_ptr_d;
    logic [pw-1:0]         rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0] mem_q [p_fifo_depth];
    logic [data_width-1:0] mem_d [p_fifo_depth];
    logic                  do_push_s;
    logic                  do_pop_s;

    // Status flags and head word, all decoded from registered state.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                  (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
        head_o  = mem_q[rd_ptr_q[aw-1:0]];
    end

    // Next pointer/storage state; clear outranks push and pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        // A push at full is only safe when the head leaves in the same cycle.
        do_push_s = push_i && (!full_o || pop_i);
        do_pop_s  = pop_i && !empty_o;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q[aw-1:0]] = push_data_i;
                wr_ptr_d                = wr_ptr_q + pw'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + pw'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < p_fifo_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/systolic_array_result_collector.sv
// Drain stage after the last PE of a column chain: tracks valid tail cycles
// with a token delay line, queues the results, and limits issue by credit.
module systolic_array_result_collector
    import systolic_array_pkg::*;
#(
    parameter int data_width    = c_data_width,
    parameter int p_latency     = calc_chain_latency(c_default_pe_count),
    parameter int p_fifo_depth  = 32'd4,
    parameter int p_count_nbits = 32'd16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [data_width-1:0]    y_tail,
    input  logic                     clear,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [data_width-1:0]    out_msg,
    output logic [p_count_nbits-1:0] result_count
);

    localparam int ow = $clog2(p_fifo_depth + 32'd1);

    logic [p_latency-1:0]     vsr_q, vsr_d;
    logic [ow-1:0]            outstanding_q, outstanding_d;
    logic [p_count_nbits-1:0] result_count_q, result_count_d;
    logic                     fire_s;
    logic                     pop_s;
    logic                     capture_s;
    logic                     push_s;
    logic                     q_empty_s;
    logic                     q_full_s;
    logic [data_width-1:0]    q_head_s;

    // Handshake decode; in_rdy depends only on the credit register.
    always_comb begin
        in_rdy    = (outstanding_q < ow'(p_fifo_depth));
        out_val   = !q_empty_s;
        out_msg   = q_head_s;
        fire_s    = in_val && in_rdy;
        pop_s     = out_val && out_rdy;
        capture_s = vsr_q[p_latency-1];
        // Credit makes a capture into a full, non-draining queue impossible;
        // the gate keeps the queue intact even if that invariant broke.
        push_s    = capture_s && (!q_full_s || pop_s);
    end

    // Next state for the token line, credit counter and pop counter.
    always_comb begin
        vsr_d          = vsr_q;
        outstanding_d  = outstanding_q;
        result_count_d = result_count_q;
        if (clear) begin
            vsr_d          = '0;
            outstanding_d  = '0;
            result_count_d = '0;
        end else begin
            vsr_d[0] = fire_s;
            for (int i = 1; i < p_latency; i++) begin
                vsr_d[i] = vsr_q[i-1];
            end
            case ({fire_s, pop_s})
                2'b10:   outstanding_d = outstanding_q + ow'(1);
                2'b01:   outstanding_d = outstanding_q - ow'(1);
                default: outstanding_d = outstanding_q;
            endcase
            if (pop_s) begin
                result_count_d = result_count_q + p_count_nbits'(1);
            end else begin
                result_count_d = result_count_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsr_q          <= '0;
            outstanding_q  <= '0;
            result_count_q <= '0;
        end else begin
            vsr_q          <= vsr_d;
            outstanding_q  <= outstanding_d;
            result_count_q <= result_count_d;
        end
    end

    assign result_count = result_count_q;

    systolic_array_result_queue #(
        .data_width   (data_width),
        .p_fifo_depth (p_fifo_depth)
    ) u_queue (
        .clk         (clk),
        .rst_n       (reset),
        .clear_i     (clear),
        .push_i      (push_s),
        .push_data_i (y_tail),
        .pop_i       (pop_s),
        .full_o      (q_full_s),
        .empty_o     (q_empty_s),
        .head_o      (q_head_s)
    );

endmodule
